// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: byte-write and line-status bundle for uart_tx_fifo.
//   in_data  : byte to transmit (master -> slave)
//   in_valid : in_data valid this cycle (master -> slave)
//   in_ready : FIFO can accept a byte (slave -> master)
//   tx       : serial line, idles high (slave -> master)
//   busy     : frame in progress or FIFO non-empty (slave -> master)
//   level    : FIFO occupancy 0..4 (slave -> master)
interface uart_tx_fifo_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       tx;
    logic       busy;
    logic [2:0] level;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  tx,
        input  busy,
        input  level
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output tx,
        output busy,
        output level
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a 4-entry byte FIFO, single clock domain.
//   clk   : system clock
//   reset : synchronous active-high reset
//   bus   : slave side of uart_tx_fifo_if (in_data/in_valid/in_ready write handshake,
//           tx serial line, busy, level)
//   CLK_DIV : clock cycles per bit, legal range 2..65535
module uart_tx_fifo #(
    parameter int unsigned CLK_DIV = 434
) (
    input  logic          clk,
    input  logic          reset,
    uart_tx_fifo_if.slave bus
);

    if (CLK_DIV < 2 || CLK_DIV > 65535) begin : g_bad_clk_div
        $error("uart_tx_fifo: CLK_DIV must be in 2..65535");
    end

    localparam logic [15:0] BaudLast = 16'(CLK_DIV - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    // FIFO storage and bookkeeping
    logic [7:0] mem_q [4];
    logic [1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0] rd_ptr_q, rd_ptr_d;
    logic [2:0] count_q, count_d;

    // Transmit engine
    state_e      state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [15:0] baud_q, baud_d;
    logic        tx_q, tx_d;

    logic wr_en;
    logic pop;
    logic baud_end;

    // in_ready depends only on registered occupancy, never on in_valid.
    assign bus.in_ready = (count_q != 3'd4);
    assign bus.level    = count_q;
    assign bus.busy     = (state_q != StIdle) || (count_q != 3'd0);
    assign bus.tx       = tx_q;

    assign wr_en    = bus.in_valid && bus.in_ready;
    assign pop      = (state_q == StIdle) && (count_q != 3'd0);
    assign baud_end = (baud_q == BaudLast);

    // FIFO pointer/count next state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        unique case ({wr_en, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    // Transmit FSM next state
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        baud_d    = baud_q;
        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    shift_d   = mem_q[rd_ptr_q];
                    bit_idx_d = 3'd0;
                    baud_d    = 16'd0;
                    state_d   = StStart;
                end
            end
            StStart: begin
                if (baud_end) begin
                    baud_d  = 16'd0;
                    state_d = StData;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            StData: begin
                if (baud_end) begin
                    baud_d    = 16'd0;
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            StStop: begin
                if (baud_end) begin
                    baud_d  = 16'd0;
                    state_d = StIdle;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Line level is derived from the next state so the pin register tracks the FSM exactly.
    always_comb begin
        tx_d = 1'b1;
        if (state_d == StStart) begin
            tx_d = 1'b0;
        end else if (state_d == StData) begin
            tx_d = shift_d[0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= 2'd0;
            rd_ptr_q  <= 2'd0;
            count_q   <= 3'd0;
            state_q   <= StIdle;
            shift_q   <= 8'd0;
            bit_idx_q <= 3'd0;
            baud_q    <= 16'd0;
            tx_q      <= 1'b1;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            baud_q    <= baud_d;
            tx_q      <= tx_d;
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem_q[wr_ptr_q] <= bus.in_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench for uart_tx_fifo with CLK_DIV 4, 2 and 434 instances.
// Index 0 -> CLK_DIV=4, 1 -> CLK_DIV=2, 2 -> CLK_DIV=434.
module tb_uart_tx_fifo;

    logic clk = 1'b0;
    logic rst4, rst2, rst434;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    logic [7:0] exp0 [$];
    logic [7:0] exp1 [$];
    logic [7:0] exp2 [$];
    int         st0 [$];
    int         st1 [$];
    int         st2 [$];

    uart_tx_fifo_if bus4 ();
    uart_tx_fifo_if bus2 ();
    uart_tx_fifo_if bus434 ();

    uart_tx_fifo #(.CLK_DIV(4))   u_d4   (.clk(clk), .reset(rst4),   .bus(bus4));
    uart_tx_fifo #(.CLK_DIV(2))   u_d2   (.clk(clk), .reset(rst2),   .bus(bus2));
    uart_tx_fifo #(.CLK_DIV(434)) u_d434 (.clk(clk), .reset(rst434), .bus(bus434));

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string nm, input logic [31:0] act,
                                  input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, req, cyc);
        end
    endfunction

    function automatic logic get_tx(input int i);
        case (i)
            0:       return bus4.tx;
            1:       return bus2.tx;
            default: return bus434.tx;
        endcase
    endfunction

    function automatic logic get_rst(input int i);
        case (i)
            0:       return rst4;
            1:       return rst2;
            default: return rst434;
        endcase
    endfunction

    function automatic logic get_ready(input int i);
        case (i)
            0:       return bus4.in_ready;
            1:       return bus2.in_ready;
            default: return bus434.in_ready;
        endcase
    endfunction

    function automatic logic get_busy(input int i);
        case (i)
            0:       return bus4.busy;
            1:       return bus2.busy;
            default: return bus434.busy;
        endcase
    endfunction

    function automatic logic [2:0] get_level(input int i);
        case (i)
            0:       return bus4.level;
            1:       return bus2.level;
            default: return bus434.level;
        endcase
    endfunction

    function automatic void set_in(input int i, input logic v, input logic [7:0] d);
        case (i)
            0:       begin bus4.in_valid = v;   bus4.in_data = d;   end
            1:       begin bus2.in_valid = v;   bus2.in_data = d;   end
            default: begin bus434.in_valid = v; bus434.in_data = d; end
        endcase
    endfunction

    function automatic void push_exp(input int i, input logic [7:0] b);
        case (i)
            0:       exp0.push_back(b);
            1:       exp1.push_back(b);
            default: exp2.push_back(b);
        endcase
    endfunction

    function automatic void push_start(input int i, input int c);
        case (i)
            0:       st0.push_back(c);
            1:       st1.push_back(c);
            default: st2.push_back(c);
        endcase
    endfunction

    // Pops the expected byte for instance i; ok=0 when nothing was expected.
    task automatic pop_exp(input int i, output logic [7:0] b, output bit ok);
        ok = 1'b1;
        b  = 8'h00;
        case (i)
            0:       if (exp0.size() == 0) ok = 1'b0; else b = exp0.pop_front();
            1:       if (exp1.size() == 0) ok = 1'b0; else b = exp1.pop_front();
            default: if (exp2.size() == 0) ok = 1'b0; else b = exp2.pop_front();
        endcase
    endtask

    // Line decoder: samples every cycle of every bit slot, so slot widths are checked exactly.
    task automatic monitor(input int i, input int div);
        logic [9:0] bits;
        logic       s;
        logic [7:0] b;
        bit         glitch, aborted, ok;
        forever begin
            @(negedge clk);
            if (get_rst(i) || get_tx(i) !== 1'b0) continue;
            push_start(i, cyc);
            bits    = '0;
            glitch  = 1'b0;
            aborted = 1'b0;
            for (int k = 0; k < 10 && !aborted; k++) begin
                for (int c = 0; c < div && !aborted; c++) begin
                    if (!(k == 0 && c == 0)) @(negedge clk);
                    if (get_rst(i)) begin
                        aborted = 1'b1;
                    end else begin
                        s = get_tx(i);
                        if (c == 0) bits[k] = s;
                        else if (s !== bits[k]) glitch = 1'b1;
                    end
                end
            end
            if (aborted) continue;
            check($sformatf("framing[%0d]", i), {29'd0, bits[0], bits[9], glitch}, 32'h2);
            pop_exp(i, b, ok);
            if (!ok) check($sformatf("unexpected_frame[%0d]", i), {24'd0, bits[8:1]}, 32'hFFFF_FFFF);
            else     check($sformatf("frame_byte[%0d]", i), {24'd0, bits[8:1]}, {24'd0, b});
        end
    endtask

    task automatic to_drive(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic to_neg(input int t);
        do @(negedge clk); while (cyc < t);
    endtask

    // Holds in_valid until each byte is accepted; records acceptance cycles.
    task automatic write_seq(input int i, input logic [7:0] b [6], input int n,
                             input int chk_cyc, output int acc [6]);
        int k;
        int guard;
        k     = 0;
        guard = 0;
        acc   = '{default: -1};
        @(posedge clk);
        #1;
        set_in(i, 1'b1, b[0]);
        while (k < n && guard < 500) begin
            @(negedge clk);
            if (cyc == chk_cyc) begin
                check("full_level", {29'd0, get_level(i)}, 32'd4);
                check("full_in_ready", {31'd0, get_ready(i)}, 32'd0);
            end
            if (get_ready(i)) begin
                acc[k] = cyc;
                push_exp(i, b[k]);
                k++;
            end
            @(posedge clk);
            #1;
            if (k < n) set_in(i, 1'b1, b[k]);
            else       set_in(i, 1'b0, 8'h00);
            guard++;
        end
        if (k < n) begin
            check("write_timeout", k, n);
            set_in(i, 1'b0, 8'h00);
        end
    endtask

    task automatic wait_idle(input int i, input int bound);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (get_busy(i) && n < bound);
        check($sformatf("idle_timeout[%0d]", i), {31'd0, get_busy(i)}, 32'd0);
    endtask

    initial begin
        logic [7:0] b [6];
        int         acc [6];
        int         t0;
        int         lows;

        rst4 = 1'b1;
        rst2 = 1'b1;
        rst434 = 1'b1;
        set_in(0, 1'b0, 8'h00);
        set_in(1, 1'b0, 8'h00);
        set_in(2, 1'b0, 8'h00);
        fork
            monitor(0, 4);
            monitor(1, 2);
            monitor(2, 434);
        join_none

        repeat (3) @(posedge clk);
        #1;
        rst4 = 1'b0;
        rst2 = 1'b0;
        rst434 = 1'b0;
        @(negedge clk);
        check("rst_tx", {31'd0, bus4.tx}, 32'd1);
        check("rst_in_ready", {31'd0, bus4.in_ready}, 32'd1);
        check("rst_busy", {31'd0, bus4.busy}, 32'd0);
        check("rst_level", {29'd0, bus4.level}, 32'd0);
        check("rst_tx_434", {31'd0, bus434.tx}, 32'd1);

        // Single byte 0x55, CLK_DIV=4
        st0.delete();
        b = '{8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        write_seq(0, b, 1, -1, acc);
        t0 = acc[0];
        to_neg(t0 + 1);
        check("single_c1_level", {29'd0, bus4.level}, 32'd1);
        check("single_c1_busy", {31'd0, bus4.busy}, 32'd1);
        check("single_c1_tx", {31'd0, bus4.tx}, 32'd1);
        to_neg(t0 + 2);
        check("single_c2_tx", {31'd0, bus4.tx}, 32'd0);
        check("single_c2_level", {29'd0, bus4.level}, 32'd0);
        to_neg(t0 + 41);
        check("single_stop_tx", {31'd0, bus4.tx}, 32'd1);
        check("single_c41_busy", {31'd0, bus4.busy}, 32'd1);
        to_neg(t0 + 42);
        check("single_c42_busy", {31'd0, bus4.busy}, 32'd0);
        check("single_start_cyc", st0.size() > 0 ? st0[0] - t0 : -1, 32'd2);

        // Backpressure 0xA0..0xA5, CLK_DIV=4
        repeat (3) @(negedge clk);
        st0.delete();
        b = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        t0 = cyc + 1;
        write_seq(0, b, 6, t0 + 5, acc);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_accept_%0d", k), acc[k] - t0, k);
        end
        check("bp_accept_5", acc[5] - t0, 32'd43);
        wait_idle(0, 1000);
        check("bp_frames", st0.size(), 32'd6);
        if (st0.size() == 6) begin
            check("bp_first_start", st0[0] - t0, 32'd2);
            for (int k = 1; k < 6; k++) begin
                check($sformatf("bp_gap_%0d", k), st0[k] - st0[k - 1], 32'd41);
            end
        end

        // Extremes on CLK_DIV=2
        st1.delete();
        b = '{8'h00, 8'hFF, 8'h01, 8'h80, 8'h00, 8'h00};
        write_seq(1, b, 4, -1, acc);
        wait_idle(1, 500);
        check("ext_frames", st1.size(), 32'd4);
        if (st1.size() == 4) begin
            for (int k = 1; k < 4; k++) begin
                check($sformatf("ext_gap_%0d", k), st1[k] - st1[k - 1], 32'd21);
            end
        end

        // Reset during DATA bit 3 with two bytes still queued, CLK_DIV=4
        repeat (3) @(negedge clk);
        b = '{8'hC3, 8'h5A, 8'h3C, 8'h00, 8'h00, 8'h00};
        write_seq(0, b, 3, -1, acc);
        t0 = acc[0];
        to_drive(t0 + 19);
        rst4 = 1'b1;
        to_neg(t0 + 19);
        check("mid_level_before", {29'd0, bus4.level}, 32'd2);
        check("mid_busy_before", {31'd0, bus4.busy}, 32'd1);
        to_drive(t0 + 20);
        rst4 = 1'b0;
        exp0.delete();
        to_neg(t0 + 20);
        check("mid_tx", {31'd0, bus4.tx}, 32'd1);
        check("mid_level", {29'd0, bus4.level}, 32'd0);
        check("mid_busy", {31'd0, bus4.busy}, 32'd0);
        check("mid_in_ready", {31'd0, bus4.in_ready}, 32'd1);
        lows = 0;
        repeat (80) begin
            @(negedge clk);
            if (bus4.tx !== 1'b1) lows++;
        end
        check("mid_no_restart", lows, 32'd0);

        // Default rate 0x41, CLK_DIV=434
        st2.delete();
        b = '{8'h41, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        write_seq(2, b, 1, -1, acc);
        t0 = acc[0];
        to_neg(t0 + 2);
        check("def_start_first", {31'd0, bus434.tx}, 32'd0);
        to_neg(t0 + 2 + 433);
        check("def_start_last", {31'd0, bus434.tx}, 32'd0);
        to_neg(t0 + 2 + 434);
        check("def_bit0", {31'd0, bus434.tx}, 32'd1);
        to_neg(t0 + 2 + 4339);
        check("def_last_busy", {31'd0, bus434.busy}, 32'd1);
        check("def_last_tx", {31'd0, bus434.tx}, 32'd1);
        to_neg(t0 + 2 + 4340);
        check("def_end_busy", {31'd0, bus434.busy}, 32'd0);
        check("def_start_cyc", st2.size() > 0 ? st2[0] - t0 : -1, 32'd2);

        repeat (5) @(negedge clk);
        check("left_exp0", exp0.size(), 32'd0);
        check("left_exp1", exp1.size(), 32'd0);
        check("left_exp2", exp2.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Serial 8N1 UART transmitter with a 4-entry input FIFO. It runs directly on the PLL output clock (50 MHz system clock) and converts byte writes from the CPU/IO side into the `tx` pin waveform. Bit timing comes from an internal clocks-per-bit counter, so no second clock domain exists.

## Interface
- `CLK_DIV`, default 434: clock cycles per UART bit (50 MHz / 115200 baud). Legal range is 2..65535. Values outside this range are a configuration error, caught by an elaboration-time check.
- `clk` in 1: system clock from the PLL output. One clock drives everything.
- `reset` in 1: synchronous, active-high reset. Sampled on the rising edge of `clk`.
- `in_data` in 8: byte to transmit.
- `in_valid` in 1: `in_data` is valid this cycle.
- `in_ready` out 1: FIFO can accept a byte. A byte is written on any cycle where `in_valid && in_ready`.
- `tx` out 1: serial line. Idles high.
- `busy` out 1: high when a frame is in progress or the FIFO is non-empty.
- `level` out 3: FIFO occupancy, 0..4.

## Operation
- **FIFO**
  - 4 entries × 8 bits, using 2-bit read/write pointers plus a 3-bit count.
  - `in_ready = (count != 4)`, driven from registered state. It has no combinational path from `in_valid`.
  - A write and a pop in the same cycle leave `count` unchanged and both pointers advance.
  - When full, `in_ready` is low, so a simultaneous pop cannot admit a same-cycle write. The write is accepted the following cycle.
  - Bytes leave the FIFO in write order.
- **Transmit FSM** has states IDLE, START, DATA, STOP.
  - IDLE: `tx = 1`. If `count != 0`: pop the head into the 8-bit shift register, clear the bit counter and the baud counter, and go to START.
  - START: `tx = 0` for `CLK_DIV` cycles, then go to DATA.
  - DATA: `tx = shift[0]`, LSB first. Every `CLK_DIV` cycles the register shifts right and the 3-bit index increments. After bit 7 completes, go to STOP.
  - STOP: `tx = 1` for `CLK_DIV` cycles, then go to IDLE.
- **Baud counter** is 16 bits and counts 0..`CLK_DIV-1`. The bit period ends when count = `CLK_DIV-1`; the counter then wraps to 0.
- `busy = (state != IDLE) || (count != 0)`.
- `tx` is registered; there is no combinational glitch path to the pin.
- **Reset** (including mid-frame):
  - Returns to IDLE, flushes the FIFO (pointers and count to 0), and zeroes the counters.
  - `tx` returns high on the next edge. A truncated frame is not resumed.

## Timing
- Reset values: `tx = 1`, `in_ready = 1`, `busy = 0`, `level = 0`, state IDLE.
- Write into an empty, idle block (write accepted on edge at cycle 0):
  - Cycle 1: `level = 1`, `busy = 1`, FSM pops.
  - Cycle 2: `tx` falls (start bit), `level = 0`.
- Frame length is exactly `10*CLK_DIV` cycles of START+DATA+STOP.
- Back-to-back frames: after STOP, the FSM spends one IDLE cycle with `tx = 1` before the next start bit. The frame-to-frame period is therefore `10*CLK_DIV + 1` cycles.
- `level` and `in_ready` update on the edge following the write or pop.
- `busy` falls on the edge after the last STOP cycle, provided the FIFO is empty.

## Test plan
- **Single byte.** Reset, then `CLK_DIV=4`, write 0x55 at cycle 0. Required `tx`: high through cycle 1; low cycles 2–5; then bit values 1,0,1,0,1,0,1,0, each 4 cycles; then high for cycles 38–41. `busy` is 0 from cycle 42.
- **Backpressure.** `CLK_DIV=4`, hold `in_valid` high with 0xA0..0xA5 on consecutive cycles. Required:
  - 0xA0..0xA4 accepted on cycles 0–4.
  - `in_ready` low from cycle 5 and `level = 4`.
  - 0xA5 accepted only after the 0xA0 frame ends and 0xA1 pops.
  - Serial output order is 0xA0..0xA5.
  - Adjacent start bits are 41 cycles apart.
- **Bit order and extremes.** Send 0x00, 0xFF, 0x01, 0x80 with `CLK_DIV=2`. The decoded line matches LSB-first. The 0x01 frame shows a single high data bit at data slot 0.
- **Reset mid-frame.** Assert `reset` for 1 cycle during DATA bit 3 with `level = 2`. Required: `tx = 1`, `level = 0`, `busy = 0`, `in_ready = 1` next cycle, and no further start bit appears.
- **Default rate.** With `CLK_DIV=434`, send 0x41. The start-bit low width is exactly 434 cycles and the total frame is 4340 cycles. The reference UART model at 115200 baud decodes 'A'.
